// File: rtl/intr_pkg.sv
// Shared types and defaults for the interrupt-controller host master:
// APB and service FSM state encodings plus sizing constants.
package intr_pkg;

   localparam int NUM_INTR_DEF = 16;
   localparam int WIDTH_DEF    = $clog2(NUM_INTR_DEF);
   localparam int CNT_W        = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2,
      S_GAP  = 2'd3
   } svc_state_t;

endpackage

// File: rtl/intr_svc_engine.sv
// Interrupt service engine: accepts a pending interrupt, waits SERVICE_CYCLES,
// pulses an acknowledge, then leaves one gap cycle for the controller to update.
module intr_svc_engine
   import intr_pkg::*;
#(
   parameter int WIDTH          = WIDTH_DEF,
   parameter int SERVICE_CYCLES = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_intr_valid,
   input  logic [WIDTH-1:0] i_intr_id,
   output logic             o_serviced,
   output logic [WIDTH-1:0] o_serviced_id,
   output logic [15:0]      o_serviced_count,
   output svc_state_t       o_state
);

   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SERVICE_CYCLES - 1);

   svc_state_t       r_state;
   svc_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_id;
   logic [WIDTH-1:0] r_serviced_id;
   logic [15:0]      r_count;
   logic             w_enter_ack;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (i_intr_valid) w_state_nxt = (SERVICE_CYCLES == 1) ? S_ACK : S_WAIT;
         // The counter reaches zero on the same edge that enters S_ACK.
         S_WAIT: if (r_cnt == CNT_W'(1)) w_state_nxt = S_ACK;
         S_ACK:  w_state_nxt = S_GAP;
         S_GAP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_enter_ack = (w_state_nxt == S_ACK) && (r_state != S_ACK);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_id          <= '0;
         r_serviced_id <= '0;
         r_count       <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_IDLE && i_intr_valid) begin
            r_id  <= i_intr_id;
            r_cnt <= LOAD_VAL;
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 1'b1;
         end
         // Id and count update together with the pulse so they are valid alongside it.
         if (w_enter_ack) begin
            r_serviced_id <= (r_state == S_IDLE) ? i_intr_id : r_id;
            if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
         end
      end
   end

   assign o_serviced       = (r_state == S_ACK);
   assign o_serviced_id    = r_serviced_id;
   assign o_serviced_count = r_count;
   assign o_state          = r_state;

endmodule

// File: rtl/intr_apb_master.sv
// Host-side APB initiator: programs the priority registers on request, forwards
// single host commands, and hosts the interrupt service engine.
module intr_apb_master
   import intr_pkg::*;
#(
   parameter int NUM_INTR       = NUM_INTR_DEF,
   parameter int WIDTH          = $clog2(NUM_INTR),
   parameter int SERVICE_CYCLES = 4
) (
   input  logic             pclk_i,
   input  logic             prst_i,
   output logic [WIDTH-1:0] paddr_o,
   output logic [WIDTH-1:0] pwdata_o,
   output logic             pwrite_o,
   output logic             psel_o,
   output logic             penable_o,
   input  logic [WIDTH-1:0] prdata_i,
   input  logic             pready_i,
   input  logic             init_start_i,
   output logic             init_busy_o,
   output logic             init_done_o,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic             cmd_write_i,
   input  logic [WIDTH-1:0] cmd_addr_i,
   input  logic [WIDTH-1:0] cmd_wdata_i,
   output logic             rsp_valid_o,
   output logic [WIDTH-1:0] rsp_rdata_o,
   input  logic             intr_valid_i,
   input  logic [WIDTH-1:0] intr_to_service_i,
   output logic             intr_serviced_o,
   output logic [WIDTH-1:0] serviced_id_o,
   output logic [15:0]      serviced_count_o
);

   // Host command handshake: a command transfers on a rising edge where
   // cmd_valid_i and cmd_ready_o are both high; cmd_valid_i may be held while
   // ready is low and the command fields must stay stable until the transfer.

   apb_state_t       r_state;
   apb_state_t       w_state_nxt;
   logic [WIDTH-1:0] r_paddr;
   logic [WIDTH-1:0] r_pwdata;
   logic             r_pwrite;
   logic             r_src_init;
   logic [WIDTH-1:0] r_init_idx;
   logic             r_init_busy;
   logic             r_init_done;
   logic             r_rsp_valid;
   logic [WIDTH-1:0] r_rsp_rdata;
   logic             w_init_go;
   logic             w_cmd_take;
   logic             w_xfer_done;
   logic             w_init_last;
   svc_state_t       w_svc_state;

   assign w_init_go   = (r_state == IDLE) && init_start_i && !r_init_busy;
   // init_start_i in the same cycle wins over a waiting host command.
   assign cmd_ready_o = prst_i && (r_state == IDLE) && !r_init_busy && !init_start_i;
   assign w_cmd_take  = cmd_valid_i && cmd_ready_o;
   assign w_xfer_done = (r_state == ACCESS) && pready_i;
   assign w_init_last = (r_init_idx == WIDTH'(NUM_INTR - 1));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_init_go || r_init_busy || w_cmd_take) w_state_nxt = SETUP;
         SETUP:   w_state_nxt = ACCESS;
         ACCESS:  if (pready_i) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge pclk_i) begin
      if (!prst_i) begin
         r_state     <= IDLE;
         r_paddr     <= '0;
         r_pwdata    <= '0;
         r_pwrite    <= 1'b0;
         r_src_init  <= 1'b0;
         r_init_idx  <= '0;
         r_init_busy <= 1'b0;
         r_init_done <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_rsp_valid <= 1'b0;
         if (r_state == IDLE) begin
            if (w_init_go) begin
               r_init_busy <= 1'b1;
               r_init_idx  <= '0;
               r_src_init  <= 1'b1;
               r_paddr     <= '0;
               r_pwdata    <= '0;
               r_pwrite    <= 1'b1;
            end else if (r_init_busy) begin
               r_src_init <= 1'b1;
               r_paddr    <= r_init_idx;
               r_pwdata   <= r_init_idx;
               r_pwrite   <= 1'b1;
            end else if (w_cmd_take) begin
               r_src_init <= 1'b0;
               r_paddr    <= cmd_addr_i;
               r_pwdata   <= cmd_wdata_i;
               r_pwrite   <= cmd_write_i;
            end
         end
         if (w_xfer_done) begin
            if (r_src_init) begin
               r_init_idx <= r_init_idx + 1'b1;
               if (w_init_last) begin
                  r_init_busy <= 1'b0;
                  r_init_done <= 1'b1;
               end
            end else begin
               r_rsp_valid <= 1'b1;
               r_rsp_rdata <= r_pwrite ? '0 : prdata_i;
            end
         end
      end
   end

   assign paddr_o     = r_paddr;
   assign pwdata_o    = r_pwdata;
   assign pwrite_o    = r_pwrite;
   assign psel_o      = (r_state == SETUP) || (r_state == ACCESS);
   assign penable_o   = (r_state == ACCESS);
   assign init_busy_o = r_init_busy;
   assign init_done_o = r_init_done;
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_rdata_o = r_rsp_rdata;

   intr_svc_engine #(
      .WIDTH          (WIDTH),
      .SERVICE_CYCLES (SERVICE_CYCLES)
   ) u_svc (
      .i_clk            (pclk_i),
      .i_rst_n          (prst_i),
      .i_intr_valid     (intr_valid_i),
      .i_intr_id        (intr_to_service_i),
      .o_serviced       (intr_serviced_o),
      .o_serviced_id    (serviced_id_o),
      .o_serviced_count (serviced_count_o),
      .o_state          (w_svc_state)
   );

   logic w_unused;
   assign w_unused = ^w_svc_state;

endmodule

// File: tb/tb_intr_apb_master.sv
// Directed bench for intr_apb_master: reset, init sequence, waited read,
// command arbitration against init, interrupt servicing and reset mid-transfer.
module tb_intr_apb_master;

   localparam int W = 4;

   logic         pclk_i = 1'b0;
   logic         prst_i = 1'b0;
   logic [W-1:0] paddr_o;
   logic [W-1:0] pwdata_o;
   logic         pwrite_o;
   logic         psel_o;
   logic         penable_o;
   logic [W-1:0] prdata_i = '0;
   logic         pready_i = 1'b0;
   logic         init_start_i = 1'b0;
   logic         init_busy_o;
   logic         init_done_o;
   logic         cmd_valid_i = 1'b0;
   logic         cmd_ready_o;
   logic         cmd_write_i = 1'b0;
   logic [W-1:0] cmd_addr_i = '0;
   logic [W-1:0] cmd_wdata_i = '0;
   logic         rsp_valid_o;
   logic [W-1:0] rsp_rdata_o;
   logic         intr_valid_i = 1'b0;
   logic [W-1:0] intr_to_service_i = '0;
   logic         intr_serviced_o;
   logic [W-1:0] serviced_id_o;
   logic [15:0]  serviced_count_o;

   int checks = 0;
   int errors = 0;

   int           slave_wait = 0;
   logic [W-1:0] slave_rdata = '0;
   int           acc_cnt = 0;
   logic [2*W:0] exp_q[$];
   logic [2*W:0] obs_q[$];

   intr_apb_master dut (
      .pclk_i            (pclk_i),
      .prst_i            (prst_i),
      .paddr_o           (paddr_o),
      .pwdata_o          (pwdata_o),
      .pwrite_o          (pwrite_o),
      .psel_o            (psel_o),
      .penable_o         (penable_o),
      .prdata_i          (prdata_i),
      .pready_i          (pready_i),
      .init_start_i      (init_start_i),
      .init_busy_o       (init_busy_o),
      .init_done_o       (init_done_o),
      .cmd_valid_i       (cmd_valid_i),
      .cmd_ready_o       (cmd_ready_o),
      .cmd_write_i       (cmd_write_i),
      .cmd_addr_i        (cmd_addr_i),
      .cmd_wdata_i       (cmd_wdata_i),
      .rsp_valid_o       (rsp_valid_o),
      .rsp_rdata_o       (rsp_rdata_o),
      .intr_valid_i      (intr_valid_i),
      .intr_to_service_i (intr_to_service_i),
      .intr_serviced_o   (intr_serviced_o),
      .serviced_id_o     (serviced_id_o),
      .serviced_count_o  (serviced_count_o)
   );

   // Clock / reset
   always #5 pclk_i = ~pclk_i;

   // APB slave: pready after slave_wait extra ACCESS cycles; logs completed transfers.
   always @(negedge pclk_i) begin
      if (psel_o === 1'b1 && penable_o === 1'b1) begin
         pready_i = (acc_cnt >= slave_wait);
         acc_cnt  = acc_cnt + 1;
         if (pready_i) obs_q.push_back({pwrite_o, paddr_o, pwdata_o});
      end else begin
         pready_i = 1'b0;
         acc_cnt  = 0;
      end
      prdata_i = slave_rdata;
   end

   task automatic test_reset();
      prst_i      = 1'b0;
      cmd_valid_i = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge pclk_i);
         #1;
         checks++;
         if ({paddr_o, pwdata_o, pwrite_o, psel_o, penable_o, init_busy_o, init_done_o,
              rsp_valid_o, rsp_rdata_o, intr_serviced_o, serviced_id_o, serviced_count_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs cycle %0d: outputs not all zero (psel=%b busy=%b done=%b cnt=%h)",
                     k, psel_o, init_busy_o, init_done_o, serviced_count_o);
         end
         checks++;
         if (cmd_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_cmd_ready cycle %0d: got %b want 0", k, cmd_ready_o);
         end
      end
      cmd_valid_i = 1'b0;
      prst_i      = 1'b1;
      #1;
      checks++;
      if (cmd_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_cmd_ready: got %b want 1", cmd_ready_o);
      end
   endtask

   task automatic test_init();
      logic [1:0] exp_pe;
      obs_q.delete();
      exp_q.delete();
      slave_wait = 0;
      @(negedge pclk_i);
      init_start_i = 1'b1;
      @(negedge pclk_i);
      init_start_i = 1'b0;
      for (int k = 0; k < 48; k++) begin
         if (k > 0) @(negedge pclk_i);
         exp_pe = {(k % 3) != 2, (k % 3) == 1};
         checks++;
         if ({psel_o, penable_o} !== exp_pe) begin
            errors++;
            $display("FAIL init_phase k=%0d: psel/penable got %b want %b", k, {psel_o, penable_o}, exp_pe);
         end
         if (k == 0 || k == 46 || k == 47) begin
            checks++;
            if ({init_busy_o, init_done_o} !== {k < 47, k == 47}) begin
               errors++;
               $display("FAIL init_status k=%0d: busy/done got %b want %b", k,
                        {init_busy_o, init_done_o}, {k < 47, k == 47});
            end
         end
      end
      for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, W'(i), W'(i)});
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL init_count: got %0d transfers want %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < 16 && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL init_write %0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_read_wait();
      slave_wait  = 3;
      slave_rdata = 4'hA;
      @(negedge pclk_i);
      cmd_valid_i = 1'b1;
      cmd_write_i = 1'b0;
      cmd_addr_i  = 4'd5;
      cmd_wdata_i = 4'hF;
      #1;
      checks++;
      if (cmd_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL read_ready: got %b want 1", cmd_ready_o);
      end
      @(negedge pclk_i);
      cmd_valid_i = 1'b0;
      for (int k = 0; k < 7; k++) begin
         if (k > 0) @(negedge pclk_i);
         checks++;
         if ({psel_o, penable_o, rsp_valid_o} !== {k <= 4, k >= 1 && k <= 4, k == 5}) begin
            errors++;
            $display("FAIL read_phase k=%0d: psel/pen/rsp got %b want %b", k,
                     {psel_o, penable_o, rsp_valid_o}, {k <= 4, k >= 1 && k <= 4, k == 5});
         end
         if (k <= 4) begin
            checks++;
            if ({paddr_o, pwrite_o} !== {4'd5, 1'b0}) begin
               errors++;
               $display("FAIL read_addr k=%0d: addr/write got %h/%b want 5/0", k, paddr_o, pwrite_o);
            end
         end else begin
            checks++;
            if (rsp_rdata_o !== 4'hA) begin
               errors++;
               $display("FAIL read_data k=%0d: got %h want a", k, rsp_rdata_o);
            end
         end
      end
   endtask

   task automatic test_cmd_during_init();
      int first_rdy = -1;
      int bad_rdy   = 0;
      obs_q.delete();
      slave_wait = 0;
      @(negedge pclk_i);
      init_start_i = 1'b1;
      cmd_valid_i  = 1'b1;
      cmd_write_i  = 1'b1;
      cmd_addr_i   = 4'd3;
      cmd_wdata_i  = 4'd9;
      #1;
      checks++;
      if (cmd_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL init_beats_cmd: cmd_ready got %b want 0", cmd_ready_o);
      end
      for (int k = 0; k < 60; k++) begin
         @(negedge pclk_i);
         if (k == 0) init_start_i = 1'b0;
         if (first_rdy >= 0 && k == first_rdy + 1) cmd_valid_i = 1'b0;
         #1;
         if (k == 0) begin
            checks++;
            if ({init_busy_o, init_done_o} !== 2'b11) begin
               errors++;
               $display("FAIL restart_status: busy/done got %b want 11", {init_busy_o, init_done_o});
            end
         end
         if (cmd_ready_o === 1'b1 && init_busy_o !== 1'b0) bad_rdy++;
         if (cmd_ready_o === 1'b1 && first_rdy < 0) first_rdy = k;
      end
      checks++;
      if (bad_rdy != 0) begin
         errors++;
         $display("FAIL ready_while_busy: got %0d cycles want 0", bad_rdy);
      end
      checks++;
      if (first_rdy != 47) begin
         errors++;
         $display("FAIL cmd_ready_release: got cycle %0d want 47", first_rdy);
      end
      checks++;
      if (obs_q.size() != 17) begin
         errors++;
         $display("FAIL cmd_once_count: got %0d transfers want 17", obs_q.size());
      end else begin
         checks++;
         if (obs_q[15] !== {1'b1, 4'd15, 4'd15} || obs_q[16] !== {1'b1, 4'd3, 4'd9}) begin
            errors++;
            $display("FAIL cmd_after_init: got %h,%h want 1ff,139", obs_q[15], obs_q[16]);
         end
      end
   endtask

   task automatic test_service();
      @(negedge pclk_i);
      intr_valid_i      = 1'b1;
      intr_to_service_i = 4'd7;
      @(negedge pclk_i);
      for (int k = 0; k < 16; k++) begin
         if (k > 0) @(negedge pclk_i);
         if (k == 0) intr_to_service_i = 4'd2;
         if (k == 6) intr_valid_i = 1'b0;
         checks++;
         if (intr_serviced_o !== (k == 3 || k == 9)) begin
            errors++;
            $display("FAIL svc_pulse k=%0d: got %b want %b", k, intr_serviced_o, (k == 3 || k == 9));
         end
         if (k == 3) begin
            checks++;
            if ({serviced_id_o, serviced_count_o} !== {4'd7, 16'd1}) begin
               errors++;
               $display("FAIL svc_first: id/count got %h/%0d want 7/1", serviced_id_o, serviced_count_o);
            end
         end
         if (k == 9) begin
            checks++;
            if ({serviced_id_o, serviced_count_o} !== {4'd2, 16'd2}) begin
               errors++;
               $display("FAIL svc_second: id/count got %h/%0d want 2/2", serviced_id_o, serviced_count_o);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int rsp_seen = 0;
      slave_wait = 5;
      @(negedge pclk_i);
      cmd_valid_i = 1'b1;
      cmd_write_i = 1'b0;
      cmd_addr_i  = 4'd2;
      @(negedge pclk_i);
      cmd_valid_i = 1'b0;
      @(negedge pclk_i);
      checks++;
      if (penable_o !== 1'b1) begin
         errors++;
         $display("FAIL mid_in_access: penable got %b want 1", penable_o);
      end
      prst_i = 1'b0;
      @(negedge pclk_i);
      checks++;
      if ({psel_o, penable_o, init_done_o, rsp_valid_o, serviced_count_o} !== '0) begin
         errors++;
         $display("FAIL mid_reset: psel/pen/done/rsp got %b cnt %0d want 0000 cnt 0",
                  {psel_o, penable_o, init_done_o, rsp_valid_o}, serviced_count_o);
      end
      @(negedge pclk_i);
      prst_i = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge pclk_i);
         if (rsp_valid_o !== 1'b0 || psel_o !== 1'b0) rsp_seen++;
      end
      checks++;
      if (rsp_seen != 0) begin
         errors++;
         $display("FAIL mid_no_rsp: got %0d active cycles want 0", rsp_seen);
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_read_wait();
      test_cmd_during_init();
      test_service();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
